loop_nest_counter: RTL and testbench

LOOP_NEST_COUNTER -- requirements
Module: loop_nest_counter

---
 rtl/loop_nest_counter_if.sv | 26 ++
 rtl/loop_nest_counter.sv | 79 +++++++
 tb/tb_loop_nest_counter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/loop_nest_counter_if.sv
// loop_nest_counter_if: configuration, control and status bundle for loop_nest_counter
interface loop_nest_counter_if #(
    parameter int WIDTH  = 4,
    parameter int LEVELS = 3
);
    logic                      cfg_load;
    logic [LEVELS*WIDTH-1:0]   cfg_max;
    logic [LEVELS*WIDTH-1:0]   cfg_step;
    logic                      cfg_repeat;
    logic                      start;
    logic                      en;
    logic                      clear;
    logic [LEVELS*WIDTH-1:0]   count;
    logic [LEVELS-1:0]         wrap;
    logic                      last;
    logic                      busy;
    logic                      done;
    modport master (
        output cfg_load, cfg_max, cfg_step, cfg_repeat, start, en, clear,
        input  count, wrap, last, busy, done
    );
    modport slave (
        input  cfg_load, cfg_max, cfg_step, cfg_repeat, start, en, clear,
        output count, wrap, last, busy, done
    );
endinterface

// File: rtl/loop_nest_counter.sv
// loop_nest_counter: configurable nested loop counter with per-level wrap pulses
module loop_nest_counter #(
    parameter int WIDTH  = 4,
    parameter int LEVELS = 3
) (
    input logic                clk,
    input logic                rst,
    loop_nest_counter_if.slave s
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                         state_q, state_d;
    logic [LEVELS-1:0][WIDTH-1:0]   cnt_q, cnt_d, max_q, max_d, step_q, step_d, stp;
    logic [LEVELS-1:0]              wrap_q, wrap_d, fin;
    logic                           done_q, done_d, rep_q, rep_d, carry;
    always_comb begin
        stp     = '0;
        fin     = '0;
        cnt_d   = cnt_q;
        wrap_d  = '0;
        state_d = state_q;
        max_d   = max_q;
        step_d  = step_q;
        rep_d   = rep_q;
        carry   = (state_q == RUN) && s.en;
        // sums are widened by one bit so a large step never overflows into a false "not final"
        for (int i = 0; i < LEVELS; i++) begin
            stp[i]    = (step_q[i] == '0) ? WIDTH'(1) : step_q[i];
            fin[i]    = ({1'b0, cnt_q[i]} + {1'b0, stp[i]}) > {1'b0, max_q[i]};
            wrap_d[i] = carry && fin[i];
            if (carry)
                cnt_d[i] = fin[i] ? '0 : cnt_q[i] + stp[i];
            carry = carry && fin[i];
        end
        done_d = carry;
        if (carry && !rep_q)
            state_d = IDLE;
        if (state_q == IDLE) begin
            if (s.cfg_load) begin
                max_d  = s.cfg_max;
                step_d = s.cfg_step;
                rep_d  = s.cfg_repeat;
            end
            if (s.start) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
        if (s.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            wrap_d  = '0;
            done_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wrap_q  <= '0;
            done_q  <= 1'b0;
            max_q   <= '0;
            step_q  <= {LEVELS{WIDTH'(1)}};
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            max_q   <= max_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
        end
    end
    assign s.count = cnt_q;
    assign s.wrap  = wrap_q;
    assign s.done  = done_q;
    assign s.busy  = (state_q == RUN);
    assign s.last  = (state_q == RUN) && (&fin);
endmodule

// File: tb/tb_loop_nest_counter.sv
// tb_loop_nest_counter: table-driven and scoreboarded checks of loop_nest_counter
module tb_loop_nest_counter;
    localparam int W = 4;
    localparam int L = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    loop_nest_counter_if #(.WIDTH(W), .LEVELS(L)) s ();
    loop_nest_counter #(.WIDTH(W), .LEVELS(L)) dut (.clk(clk), .rst(rst), .s(s));
    typedef struct {
        logic        rs, ld;
        logic [11:0] mx, st;
        logic        rp, sta, en, clr;
        logic [11:0] cnt;
        logic [2:0]  wr;
        logic        bsy, dn;
    } vec_t;
    typedef struct {
        logic [11:0] cnt;
        logic [2:0]  wr;
        logic        bsy, dn;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[$];
    int checks = 0;
    int failures = 0;
    int w0_pulses;
    function automatic vec_t mk(logic rs, logic ld, logic [11:0] mx, logic [11:0] st, logic rp,
                                logic sta, logic en, logic clr, logic [11:0] cnt, logic [2:0] wr,
                                logic bsy, logic dn);
        vec_t v;
        v.rs = rs; v.ld = ld; v.mx = mx; v.st = st; v.rp = rp; v.sta = sta; v.en = en;
        v.clr = clr; v.cnt = cnt; v.wr = wr; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction
    function automatic logic [11:0] cexp(int k);
        int j = k % 24;
        return {4'((j / 6) % 4), 4'((j / 2) % 3), 4'(j % 2)};
    endfunction
    task automatic chk(string n, logic [11:0] a, logic [11:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic apply(string tag, vec_t v);
        exp_t e;
        rst = v.rs; s.cfg_load = v.ld; s.cfg_max = v.mx; s.cfg_step = v.st;
        s.cfg_repeat = v.rp; s.start = v.sta; s.en = v.en; s.clear = v.clr;
        e.cnt = v.cnt; e.wr = v.wr; e.bsy = v.bsy; e.dn = v.dn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".count"}, s.count, e.cnt);
        chk({tag, ".wrap"}, 12'(s.wrap), 12'(e.wr));
        chk({tag, ".busy"}, 12'(s.busy), 12'(e.bsy));
        chk({tag, ".done"}, 12'(s.done), 12'(e.dn));
        if (s.wrap[0]) w0_pulses++;
    endtask
    initial begin
        s.cfg_load = 0; s.cfg_max = 0; s.cfg_step = 0; s.cfg_repeat = 0;
        s.start = 0; s.en = 0; s.clear = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", s.count, 12'h000);
        chk("rst.wrap", 12'(s.wrap), 12'h0);
        chk("rst.busy", 12'(s.busy), 12'h0);
        chk("rst.done", 12'(s.done), 12'h0);
        chk("rst.last", 12'(s.last), 12'h0);
        // step rounding
        tbl.push_back(mk(0,1,12'hFF7,12'h113,0,0,0,0, 12'h000,3'b000,0,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h113,0,1,0,0, 12'h000,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h113,0,0,1,0, 12'h003,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h113,0,0,0,0, 12'h003,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h113,0,0,1,0, 12'h006,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h113,0,0,1,0, 12'h010,3'b001,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h113,0,0,0,0, 12'h010,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h113,0,0,0,1, 12'h000,3'b000,0,0));
        tbl.push_back(mk(0,1,12'hFF7,12'h110,0,0,0,0, 12'h000,3'b000,0,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h110,0,1,0,0, 12'h000,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h110,0,0,1,0, 12'h001,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h110,0,0,1,0, 12'h002,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h110,0,0,1,0, 12'h003,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFF7,12'h110,0,0,0,1, 12'h000,3'b000,0,0));
        // no overflow at the top of the range
        tbl.push_back(mk(0,1,12'hFFF,12'h11F,0,0,0,0, 12'h000,3'b000,0,0));
        tbl.push_back(mk(0,0,12'hFFF,12'h11F,0,1,0,0, 12'h000,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFFF,12'h11F,0,0,1,0, 12'h00F,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFFF,12'h11F,0,0,1,0, 12'h010,3'b001,1,0));
        tbl.push_back(mk(0,0,12'hFFF,12'h11F,0,0,1,0, 12'h01F,3'b000,1,0));
        tbl.push_back(mk(0,0,12'hFFF,12'h11F,0,0,0,1, 12'h000,3'b000,0,0));
        // priority and ignored start in RUN
        tbl.push_back(mk(0,1,12'h321,12'h111,0,0,0,0, 12'h000,3'b000,0,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,1,0,0, 12'h000,3'b000,1,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,0,1,0, 12'h001,3'b000,1,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,1,1,1, 12'h000,3'b000,0,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,1,0,0, 12'h000,3'b000,1,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,0,1,0, 12'h001,3'b000,1,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,1,1,0, 12'h010,3'b001,1,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,0,0,1, 12'h000,3'b000,0,0));
        tbl.push_back(mk(0,0,12'h321,12'h111,0,0,1,0, 12'h000,3'b000,0,0));
        for (int i = 0; i < tbl.size(); i++) apply($sformatf("v%0d", i), tbl[i]);
        // single pass of 24 advances
        apply("pass.start", mk(0,0,12'h321,12'h111,0,1,0,0, 12'h000,3'b000,1,0));
        w0_pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            chk($sformatf("pass%0d.last", k), 12'(s.last), 12'(k == 24));
            apply($sformatf("pass%0d", k), mk(0,0,12'h321,12'h111,0,0,1,0, cexp(k),
                  {k == 24, k % 6 == 0, k % 2 == 0}, k < 24, k == 24));
        end
        chk("pass.wrap0_pulses", 12'(w0_pulses), 12'd12);
        chk("idle.last", 12'(s.last), 12'h0);
        apply("idle_en", mk(0,0,12'h321,12'h111,0,0,1,0, 12'h000,3'b000,0,0));
        // continuous mode with a cfg_load attempt mid-pass
        apply("rep.load", mk(0,1,12'h321,12'h111,1,0,0,0, 12'h000,3'b000,0,0));
        apply("rep.start", mk(0,0,12'h321,12'h111,1,1,0,0, 12'h000,3'b000,1,0));
        w0_pulses = 0;
        for (int k = 1; k <= 48; k++) begin
            chk($sformatf("rep%0d.last", k), 12'(s.last), 12'((k - 1) % 24 == 23));
            apply($sformatf("rep%0d", k), mk(0, k == 5, 12'h000, 12'h000, 0, 0, 1, 0, cexp(k),
                  {k % 24 == 0, k % 6 == 0, k % 2 == 0}, 1, k % 24 == 0));
        end
        chk("rep.wrap0_pulses", 12'(w0_pulses), 12'd24);
        apply("rep.clear", mk(0,0,12'h321,12'h111,1,0,0,1, 12'h000,3'b000,0,0));
        // reset mid-pass at counts {0,2,1}
        apply("mid.start", mk(0,0,12'h321,12'h111,1,1,0,0, 12'h000,3'b000,1,0));
        for (int k = 1; k <= 5; k++)
            apply($sformatf("mid%0d", k), mk(0,0,12'h321,12'h111,1,0,1,0, cexp(k),
                  {1'b0, k % 6 == 0, k % 2 == 0}, 1, 0));
        chk("mid.count", s.count, 12'h021);
        apply("mid.rst", mk(1,0,12'h321,12'h111,1,0,1,0, 12'h000,3'b000,0,0));
        chk("mid.last", 12'(s.last), 12'h0);
        for (int k = 0; k < 3; k++)
            apply($sformatf("post_rst%0d", k), mk(0,0,12'h321,12'h111,1,0,1,0, 12'h000,3'b000,0,0));
        // reset configuration: max 0, step 1, single pass
        apply("rcfg.start", mk(0,0,12'h000,12'h000,0,1,0,0, 12'h000,3'b000,1,0));
        chk("rcfg.last", 12'(s.last), 12'h1);
        apply("rcfg.en", mk(0,0,12'h000,12'h000,0,0,1,0, 12'h000,3'b111,0,1));
        apply("rcfg.after", mk(0,0,12'h000,12'h000,0,0,0,0, 12'h000,3'b000,0,0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
